fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
- Frame scheduler in front of fft_multipoint.
- Accepts a valid/ready sample stream plus a per-frame size request.
- Latches the FFT size at each frame start and drives the FFT's np/sop_in/stb/x_re/x_im with the continuous one-sample-per-cycle cadence the pipeline requires.
- Holds off the next frame until the 3N/2-cycle frame window has elapsed, then tracks output frames for completion and error reporting.

Parameters:
DW, 16, sample component width
GAP, 0, extra idle cycles enforced after each 3N/2 window (0..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_np  in  4  size code for the next frame (0->8 … 8->2048); sampled on the frame's sop beat
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_sop  in  1  first sample of a frame
s_re  in  DW  input real
s_im  in  DW  input imag
fft_np  out  4  size code to FFT, held stable for the whole frame window
fft_sop  out  1  to FFT sop_in
fft_stb  out  1  to FFT stb
fft_re  out  DW  to FFT x_re
fft_im  out  DW  to FFT x_im
fft_vout  in  1  FFT valid_out
frm_done  out  1  one-cycle pulse on the last output sample of a frame
done_np  out  4  size code of the completed frame, valid with frm_done
busy  out  1  state != IDLE
err_sop  out  1  sticky: stray sop mid-frame or non-sop beat in IDLE
err_unf  out  1  sticky: s_valid low during LOAD
err_np  out  1  sticky: cfg_np > 8 received

Behaviour:
Reset values:
- All outputs 0; fft_np = 0; state IDLE; queue empty; counters 0.
- Reset mid-frame aborts immediately and clears the queue.

States and transitions:
- IDLE:
  - s_ready = !q_full.
  - Beat with s_sop: latch np (cfg_np > 8 coerced to 0 and err_np set), push np into the queue, cyc = 1, go to LOAD.
  - Beat without s_sop: dropped, err_sop set.
- LOAD:
  - s_ready = 1; one FFT sample issued every cycle.
  - A cycle with s_valid = 0 issues a zero sample (stb = 1) and sets err_unf; no stalling is allowed.
  - s_sop in LOAD: treated as data, err_sop set.
  - When cyc == N: go to DRAIN.
- DRAIN:
  - s_ready = 0; fft_stb = 0.
  - When cyc == 3N/2 - 1 + GAP: go to IDLE.
  - cyc increments every cycle from LOAD onward.

FFT drive and frame length:
- fft_* outputs are registered: 1-cycle latency from the accepted beat.
- fft_sop is high exactly on the first issued sample.
- N = 8 << np_latched. A frame issues exactly N stb cycles.
- The IDLE->LOAD transition is allowed in the same cycle the DRAIN->IDLE edge completes (back-to-back frames when GAP = 0).

Output monitor:
- Counts fft_vout beats against N of the queue head.
- On the Nth beat: frm_done = 1, done_np = head, pop, count cleared.
- fft_vout with the queue empty: ignored, err_sop set.
- Simultaneous push and pop is legal; occupancy stays the same.

Queue:
- 2-entry FIFO.
- Full blocks new frames in IDLE (s_ready = 0).

Error flags:
- Sticky until reset.

Optional Feature:
- FFT_SCHED_STATS_EN defined: adds output frm_cnt [15:0], incremented on each frm_done and wrapping at 0xFFFF, and output unf_cnt [15:0], incremented on each zero-fill cycle and saturating at 0xFFFF.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- cfg_np = 0, 8 continuous beats with sop on the first, GAP = 0 -> fft_sop on cycle 1 after acceptance; 8 fft_stb; s_ready low for cycles 9..11; IDLE at cyc = 11.
- Two back-to-back np = 1 frames, with fft_vout model returning 16 beats per frame -> two frm_done pulses, done_np = 1 each; queue never blocks.
- cfg_np = 12 -> err_np = 1, frame runs as N = 8, fft_np = 0.
- s_valid dropped for 2 cycles mid-LOAD (np = 0) -> 2 zero samples issued, err_unf = 1, still exactly 8 stb.
- Non-sop beat in IDLE, then sop mid-LOAD -> err_sop = 1; first beat discarded, second issued as data.
- Queue full (fft_vout held low, 2 frames issued) -> third sop stalled with s_ready = 0 until frm_done of frame 1.

Source files
------------

// File: rtl/fft_frame_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_frame_sched                                                 |
// | Purpose  : Frame scheduler in front of fft_multipoint. Accepts a           |
// |            valid/ready sample stream with a per-frame size code, latches  |
// |            the size at frame start, and feeds the FFT one sample per      |
// |            cycle with no stalls. The next frame is held off until the     |
// |            frame window (3N/2 - 1 + GAP cycles) has elapsed. A 2-entry    |
// |            queue of in-flight size codes lets an output monitor count     |
// |            fft_vout beats and flag completed frames.                      |
// | Ports    : clk, rst_n (async, active low)                                 |
// |            cfg_np, s_valid/s_ready/s_sop/s_re/s_im : input sample stream  |
// |            fft_np/fft_sop/fft_stb/fft_re/fft_im    : FFT drive (registered)|
// |            fft_vout                                : FFT output valid     |
// |            frm_done/done_np                        : frame completion     |
// |            busy, err_sop/err_unf/err_np            : status, sticky errors|
// |            frm_cnt/unf_cnt (FFT_SCHED_STATS_EN)     : statistics counters  |
// | Options  : `define FFT_SCHED_STATS_EN adds frm_cnt and unf_cnt outputs.    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fft_frame_sched #(
  parameter int DW  = 16,
  parameter int GAP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    cfg_np,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sop,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  output logic [3:0]    fft_np,
  output logic          fft_sop,
  output logic          fft_stb,
  output logic [DW-1:0] fft_re,
  output logic [DW-1:0] fft_im,
  input  logic          fft_vout,
  output logic          frm_done,
  output logic [3:0]    done_np,
  output logic          busy,
  output logic          err_sop,
  output logic          err_unf,
  output logic          err_np
`ifdef FFT_SCHED_STATS_EN
  ,
  output logic [15:0]   frm_cnt,
  output logic [15:0]   unf_cnt
`endif
);

  localparam logic [11:0] c_gap    = 12'(GAP);
  localparam logic [3:0]  c_np_max = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_cyc;

  // size-code queue (2 entries) and output monitor
  logic [3:0]  r_q [2];
  logic        r_wr;
  logic        r_rd;
  logic [1:0]  r_qcnt;
  logic [11:0] r_mon_cnt;

  logic        w_q_full;
  logic        w_q_empty;
  logic        w_beat;
  logic        w_accept;
  logic [3:0]  w_np_in;
  logic [11:0] w_n;
  logic [11:0] w_end;
  logic [3:0]  w_head;
  logic [11:0] w_head_n;
  logic        w_pop;
  logic        w_set_sop;
  logic        w_set_unf;
  logic        w_set_np;

  assign w_q_full  = (r_qcnt == 2'd2);
  assign w_q_empty = (r_qcnt == 2'd0);

  // Ready is held low while in reset so every output reads 0 there.
  assign s_ready = rst_n &&
                   ((r_state == S_LOAD) || ((r_state == S_IDLE) && !w_q_full));

  assign w_beat   = s_valid && s_ready;
  assign w_accept = (r_state == S_IDLE) && w_beat && s_sop;
  assign w_np_in  = (cfg_np > c_np_max) ? 4'd0 : cfg_np;

  // Frame length and window end for the latched size code.
  assign w_n   = 12'd8 << fft_np;
  assign w_end = w_n + (w_n >> 1) - 12'd1 + c_gap;

  assign busy = (r_state != S_IDLE);

  // Error sources, merged into one sticky-flag register below.
  assign w_set_sop = ((r_state == S_IDLE) && w_beat && !s_sop) ||
                     ((r_state == S_LOAD) && s_valid && s_sop) ||
                     (fft_vout && w_q_empty);
  assign w_set_unf = (r_state == S_LOAD) && !s_valid;
  assign w_set_np  = w_accept && (cfg_np > c_np_max);

  // --------------------------------------------------------------------------
  // Input FSM and registered FFT drive
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= 12'd0;
      fft_np  <= 4'd0;
      fft_sop <= 1'b0;
      fft_stb <= 1'b0;
      fft_re  <= '0;
      fft_im  <= '0;
    end else begin
      fft_sop <= 1'b0;
      fft_stb <= 1'b0;
      fft_re  <= '0;
      fft_im  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            fft_np  <= w_np_in;
            fft_sop <= 1'b1;
            fft_stb <= 1'b1;
            fft_re  <= s_re;
            fft_im  <= s_im;
            r_cyc   <= 12'd1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // One sample every cycle; a missing input beat becomes a zero
          // sample so the FFT cadence is never broken.
          fft_stb <= 1'b1;
          if (s_valid) begin
            fft_re <= s_re;
            fft_im <= s_im;
          end
          r_cyc <= r_cyc + 12'd1;
          if (r_cyc == w_n - 12'd1) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Return to IDLE in the cycle the count would reach the window
          // end, so that cycle can already accept the next frame's sop.
          if (r_cyc + 12'd1 == w_end) begin
            r_cyc   <= 12'd0;
            r_state <= S_IDLE;
          end else begin
            r_cyc <= r_cyc + 12'd1;
          end
        end
        default: begin
          r_cyc   <= 12'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Size-code queue and output monitor
  // --------------------------------------------------------------------------
  assign w_head   = r_q[r_rd];
  assign w_head_n = 12'd8 << w_head;
  assign w_pop    = fft_vout && !w_q_empty && (r_mon_cnt == w_head_n - 12'd1);

  // Completion is flagged combinationally on the last output beat itself.
  assign frm_done = w_pop;
  assign done_np  = w_pop ? w_head : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q[0]    <= 4'd0;
      r_q[1]    <= 4'd0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_qcnt    <= 2'd0;
      r_mon_cnt <= 12'd0;
    end else begin
      if (w_accept) begin
        r_q[r_wr] <= w_np_in;
        r_wr      <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_accept, w_pop})
        2'b10:   r_qcnt <= r_qcnt + 2'd1;
        2'b01:   r_qcnt <= r_qcnt - 2'd1;
        default: r_qcnt <= r_qcnt;
      endcase
      if (fft_vout && !w_q_empty) begin
        r_mon_cnt <= w_pop ? 12'd0 : r_mon_cnt + 12'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sop <= 1'b0;
      err_unf <= 1'b0;
      err_np  <= 1'b0;
    end else begin
      if (w_set_sop) err_sop <= 1'b1;
      if (w_set_unf) err_unf <= 1'b1;
      if (w_set_np)  err_np  <= 1'b1;
    end
  end

`ifdef FFT_SCHED_STATS_EN
  // frm_cnt wraps naturally; unf_cnt saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt <= 16'd0;
      unf_cnt <= 16'd0;
    end else begin
      if (w_pop) frm_cnt <= frm_cnt + 16'd1;
      if (w_set_unf && (unf_cnt != 16'hFFFF)) unf_cnt <= unf_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_frame_sched                                              |
// | Purpose  : Directed self-checking bench for fft_frame_sched (GAP = 0).     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_fft_frame_sched;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    cfg_np = 4'd0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_sop = 1'b0;
  logic [DW-1:0] s_re = '0;
  logic [DW-1:0] s_im = '0;
  logic [3:0]    fft_np;
  logic          fft_sop;
  logic          fft_stb;
  logic [DW-1:0] fft_re;
  logic [DW-1:0] fft_im;
  logic          fft_vout = 1'b0;
  logic          frm_done;
  logic [3:0]    done_np;
  logic          busy;
  logic          err_sop;
  logic          err_unf;
  logic          err_np;
`ifdef FFT_SCHED_STATS_EN
  logic [15:0]   frm_cnt;
  logic [15:0]   unf_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_tb = 0;
  int stb_cnt = 0;

  fft_frame_sched #(.DW(DW), .GAP(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_np   (cfg_np),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sop    (s_sop),
    .s_re     (s_re),
    .s_im     (s_im),
    .fft_np   (fft_np),
    .fft_sop  (fft_sop),
    .fft_stb  (fft_stb),
    .fft_re   (fft_re),
    .fft_im   (fft_im),
    .fft_vout (fft_vout),
    .frm_done (frm_done),
    .done_np  (done_np),
    .busy     (busy),
    .err_sop  (err_sop),
    .err_unf  (err_unf),
    .err_np   (err_np)
`ifdef FFT_SCHED_STATS_EN
    ,
    .frm_cnt  (frm_cnt),
    .unf_cnt  (unf_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_tb <= cyc_tb + 1;
  always @(negedge clk) if (fft_stb) stb_cnt <= stb_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!s_ready && k < 100) begin
      tick();
      k++;
    end
    chk("rdy_wait", 32'(s_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic send_frame(input logic [3:0] np, input int n, input logic [15:0] base,
                            output int t_acc);
    t_acc = 0;
    for (int i = 0; i < n; i++) begin
      cfg_np  = np;
      s_valid = 1'b1;
      s_sop   = (i == 0);
      s_re    = base + 16'(i);
      s_im    = ~(base + 16'(i));
      wait_ready();
      if (i == 0) t_acc = cyc_tb;
      tick();
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
  endtask

  task automatic vout_beats(input int n, input logic [3:0] exp_np);
    for (int i = 0; i < n; i++) begin
      fft_vout = 1'b1;
      #1;
      chk("frm_done", 32'(frm_done), (i == n - 1) ? 32'd1 : 32'd0);
      if (i == n - 1) chk("done_np", 32'(done_np), 32'(exp_np));
      tick();
    end
    fft_vout = 1'b0;
  endtask

  initial begin
    int ta, tb, s0;

    // ---------------- reset ----------------
    tick(); tick(); tick();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_stb",   32'(fft_stb), 32'd0);
    chk("rst_np",    32'(fft_np), 32'd0);
    chk("rst_done",  32'(frm_done), 32'd0);
    chk("rst_err",   32'({err_sop, err_unf, err_np}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(s_ready), 32'd1);

    // ---------------- np = 0, single frame, cadence and window ----------------
    s0 = stb_cnt;
    for (int i = 0; i < 8; i++) begin
      cfg_np  = 4'd0;
      s_valid = 1'b1;
      s_sop   = (i == 0);
      s_re    = 16'h0100 + 16'(i);
      s_im    = 16'h0200 + 16'(i);
      tick();
      chk("t1_stb", 32'(fft_stb), 32'd1);
      chk("t1_re",  32'(fft_re), 32'h0100 + 32'(i));
      chk("t1_im",  32'(fft_im), 32'h0200 + 32'(i));
      chk("t1_sop", 32'(fft_sop), (i == 0) ? 32'd1 : 32'd0);
      if (i == 0) begin
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_np",   32'(fft_np), 32'd0);
      end
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
    chk("t1_rdy_lo0", 32'(s_ready), 32'd0);
    tick();
    chk("t1_rdy_lo1", 32'(s_ready), 32'd0);
    chk("t1_stb_off", 32'(fft_stb), 32'd0);
    tick();
    chk("t1_rdy_lo2", 32'(s_ready), 32'd0);
    tick();
    chk("t1_rdy_hi", 32'(s_ready), 32'd1);
    chk("t1_idle",   32'(busy), 32'd0);
    chk("t1_nstb",   32'(stb_cnt - s0), 32'd8);
    vout_beats(8, 4'd0);

    // ---------------- two back-to-back np = 1 frames ----------------
    send_frame(4'd1, 16, 16'h1000, ta);
    send_frame(4'd1, 16, 16'h2000, tb);
    chk("t2_gap", 32'(tb - ta), 32'd23);
    chk("t2_np",  32'(fft_np), 32'd1);
    vout_beats(16, 4'd1);
    vout_beats(16, 4'd1);

    // ---------------- out-of-range size code ----------------
    chk("t3_np_pre", 32'(err_np), 32'd0);
    s0 = stb_cnt;
    send_frame(4'd12, 8, 16'h3000, ta);
    chk("t3_errnp", 32'(err_np), 32'd1);
    chk("t3_fftnp", 32'(fft_np), 32'd0);
    wait_idle();
    chk("t3_nstb", 32'(stb_cnt - s0), 32'd8);
    vout_beats(8, 4'd0);

    // ---------------- underflow: s_valid low for 2 cycles ----------------
    chk("t4_unf_pre", 32'(err_unf), 32'd0);
    s0 = stb_cnt;
    for (int i = 0; i < 8; i++) begin
      cfg_np  = 4'd0;
      s_valid = !(i == 3 || i == 4);
      s_sop   = (i == 0);
      s_re    = 16'h4000 + 16'(i);
      s_im    = 16'h4800 + 16'(i);
      if (i == 0) wait_ready();
      tick();
      chk("t4_stb", 32'(fft_stb), 32'd1);
      chk("t4_re",  32'(fft_re), (i == 3 || i == 4) ? 32'd0 : 32'h4000 + 32'(i));
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
    wait_idle();
    chk("t4_errunf", 32'(err_unf), 32'd1);
    chk("t4_nstb",   32'(stb_cnt - s0), 32'd8);
    vout_beats(8, 4'd0);

    // ---------------- stray beats: non-sop in IDLE ----------------
    chk("t5_sop_pre", 32'(err_sop), 32'd0);
    s_valid = 1'b1;
    s_sop   = 1'b0;
    s_re    = 16'h5555;
    wait_ready();
    tick();
    s_valid = 1'b0;
    chk("t5_drop_busy", 32'(busy), 32'd0);
    chk("t5_drop_stb",  32'(fft_stb), 32'd0);
    chk("t5_errsop1",   32'(err_sop), 32'd1);

    // mid-run reset clears sticky flags
    rst_n = 1'b0;
    tick();
    chk("t5_rst_err", 32'({err_sop, err_unf, err_np}), 32'd0);
    rst_n = 1'b1;
    tick();

    // sop mid-LOAD is issued as ordinary data
    s0 = stb_cnt;
    for (int i = 0; i < 8; i++) begin
      cfg_np  = 4'd0;
      s_valid = 1'b1;
      s_sop   = (i == 0 || i == 3);
      s_re    = 16'h6000 + 16'(i);
      if (i == 0) wait_ready();
      tick();
      if (i == 3) begin
        chk("t5_mid_re",  32'(fft_re), 32'h6003);
        chk("t5_mid_sop", 32'(fft_sop), 32'd0);
      end
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
    chk("t5_errsop2", 32'(err_sop), 32'd1);
    wait_idle();
    chk("t5_nstb", 32'(stb_cnt - s0), 32'd8);
    vout_beats(8, 4'd0);

    // ---------------- queue full blocks a third frame ----------------
    send_frame(4'd0, 8, 16'h7000, ta);
    send_frame(4'd0, 8, 16'h7100, ta);
    cfg_np  = 4'd0;
    s_valid = 1'b1;
    s_sop   = 1'b1;
    s_re    = 16'h7200;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      chk("t6_blocked", 32'(s_ready), 32'd0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      fft_vout = 1'b1;
      #1;
      if (i == 7) begin
        chk("t6_done",    32'(frm_done), 32'd1);
        chk("t6_rdy_pop", 32'(s_ready), 32'd0);
      end
      tick();
    end
    fft_vout = 1'b0;
    chk("t6_rdy_free", 32'(s_ready), 32'd1);
    chk("t6_idle",     32'(busy), 32'd0);
    tick();
    chk("t6_start", 32'(busy), 32'd1);
    chk("t6_sop",   32'(fft_sop), 32'd1);
    chk("t6_re",    32'(fft_re), 32'h7200);
    for (int i = 1; i < 8; i++) begin
      s_sop = 1'b0;
      s_re  = 16'h7200 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    wait_idle();
    vout_beats(8, 4'd0);
    vout_beats(8, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
